// File: rtl/uart_bus_slave_pkg.sv
// Shared types for the memory-mapped UART slave.
// Status bit positions, FSM states and bus bundles.
package uart_bus_slave_pkg;

  localparam int RX_VALID_BIT     = 8;
  localparam int RX_OVERRUN_BIT   = 9;
  localparam int TX_FULL_BIT      = 10;
  localparam int TX_IDLE_BIT      = 11;
  localparam int TX_DROPPED_BIT   = 12;
  localparam int RX_FRAME_ERR_BIT = 13;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } mem_cmd_t;

  typedef struct packed {
    logic [31:0] read_data;
  } mem_res_t;

  function automatic logic [31:0] status_word(
    input logic [7:0] rx_data,
    input logic       rx_valid,
    input logic       rx_overrun,
    input logic       tx_full,
    input logic       tx_idle,
    input logic       tx_dropped,
    input logic       rx_frame_err
  );
    return {18'd0, rx_frame_err, tx_dropped,
            tx_idle, tx_full, rx_overrun,
            rx_valid, rx_data};
  endfunction

endpackage

// File: rtl/uart_bus_slave_if.sv
// Memory bus port bundle for the UART window.
// Master drives the command, slave returns the result.
interface uart_bus_slave_if;
  import uart_bus_slave_pkg::*;

  mem_cmd_t membuscmd;
  mem_res_t membusres;

  modport master (
    output membuscmd,
    input  membusres
  );

  modport slave (
    input  membuscmd,
    output membusres
  );

endinterface

// File: rtl/uart_bus_slave_fifo.sv
// Small synchronous FIFO, head shown on dout.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB tells full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_bus_slave.sv
// Memory-mapped 8N1 UART: TX FIFO + shifter, RX sampler,
// one-byte RX holding register and W1C status flags.
module uart_bus_slave
  import uart_bus_slave_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 434,
  parameter int TX_FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_bus_slave_if.slave    bus,
  output logic               tx_o,
  input  logic               rx_i,
  output logic               irq_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

  mem_cmd_t cmd;
  assign cmd = bus.membuscmd;

  logic wr_byte;
  logic w1c;
  logic rd_pop;

  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_sh;
  logic          tx_cnt_end;
  logic          tx_bit;
  logic          tx_idle;

  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_sh;
  logic          rx_cnt_end;
  logic          rx_half;
  logic          rx_stop_hit;
  logic          rx_stop_ok;
  logic          rx_stop_bad;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       tx_dropped;
  logic       rx_frame_err;

  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd.address,
                             cmd.write_data[31:14],
                             cmd.write_data[11:10],
                             cmd.write_data[8],
                             cmd.mask_byte[3:2]};

  assign wr_byte = cmd.mem_write && cmd.mask_byte[0];
  assign w1c     = cmd.mem_write && cmd.mask_byte[1];
  assign rd_pop  = cmd.mem_read && cmd.mask_byte[0] && rx_valid;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_byte),
    .din   (cmd.write_data[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_cnt_end = (tx_cnt == CNT_MAX);
  assign fifo_pop   = !fifo_empty &&
                      ((tx_state == TX_IDLE) ||
                       ((tx_state == TX_STOP) && tx_cnt_end));
  assign tx_idle    = fifo_empty && (tx_state == TX_IDLE);
  assign tx_bit     = (tx_state == TX_START) ? 1'b0 :
                      (tx_state == TX_DATA)  ? tx_sh[0] : 1'b1;

  // TX shifter: back-to-back frames when the FIFO refills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_sh    <= fifo_dout;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_end) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_end) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b0, tx_sh[7:1]};
            if (tx_idx == 3'd7) tx_state <= TX_STOP;
            else tx_idx <= tx_idx + 3'd1;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: begin
          if (tx_cnt_end) begin
            tx_cnt <= '0;
            if (fifo_pop) begin
              tx_sh    <= fifo_dout;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Registered serial output, glitch-free, idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_o <= 1'b1;
    else     tx_o <= tx_bit;
  end

  // Two-flop synchroniser plus a delay flop for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_cnt_end  = (rx_cnt == CNT_MAX);
  assign rx_half     = (rx_cnt == CNT_HALF);
  assign rx_stop_hit = (rx_state == RX_STOP) && rx_cnt_end;
  assign rx_stop_ok  = rx_stop_hit && rx_s2;
  assign rx_stop_bad = rx_stop_hit && !rx_s2;

  // RX sampler: start check at half bit, then bit centres.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_half) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            if (rx_s2) rx_state <= RX_IDLE;
            else       rx_state <= RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_end) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else rx_idx <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: begin
          if (rx_cnt_end) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Holding register and sticky flags; a set beats a W1C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_dropped   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rx_stop_ok) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_pop) begin
        rx_valid <= 1'b0;
      end

      if (rx_stop_ok && rx_valid && !rd_pop)
        rx_overrun <= 1'b1;
      else if (w1c && cmd.write_data[RX_OVERRUN_BIT])
        rx_overrun <= 1'b0;

      if (wr_byte && fifo_full)
        tx_dropped <= 1'b1;
      else if (w1c && cmd.write_data[TX_DROPPED_BIT])
        tx_dropped <= 1'b0;

      if (rx_stop_bad)
        rx_frame_err <= 1'b1;
      else if (w1c && cmd.write_data[RX_FRAME_ERR_BIT])
        rx_frame_err <= 1'b0;
    end
  end

  assign bus.membusres.read_data = status_word(
    rx_data, rx_valid, rx_overrun, fifo_full,
    tx_idle, tx_dropped, rx_frame_err);

  assign irq_o = rx_valid;

endmodule
